// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// MIPS register names, default geometry and the counter saturation helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] AT   = 5'd1;
    localparam logic [4:0] V0   = 5'd2;
    localparam logic [4:0] V1   = 5'd3;
    localparam logic [4:0] A0   = 5'd4;
    localparam logic [4:0] A1   = 5'd5;
    localparam logic [4:0] A2   = 5'd6;
    localparam logic [4:0] A3   = 5'd7;
    localparam logic [4:0] T0   = 5'd8;
    localparam logic [4:0] T1   = 5'd9;
    localparam logic [4:0] T2   = 5'd10;
    localparam logic [4:0] T3   = 5'd11;
    localparam logic [4:0] T4   = 5'd12;
    localparam logic [4:0] T5   = 5'd13;
    localparam logic [4:0] T6   = 5'd14;
    localparam logic [4:0] T7   = 5'd15;
    localparam logic [4:0] S0   = 5'd16;
    localparam logic [4:0] S1   = 5'd17;
    localparam logic [4:0] S2   = 5'd18;
    localparam logic [4:0] S3   = 5'd19;
    localparam logic [4:0] S4   = 5'd20;
    localparam logic [4:0] S5   = 5'd21;
    localparam logic [4:0] S6   = 5'd22;
    localparam logic [4:0] S7   = 5'd23;
    localparam logic [4:0] T8   = 5'd24;
    localparam logic [4:0] T9   = 5'd25;
    localparam logic [4:0] K0   = 5'd26;
    localparam logic [4:0] K1   = 5'd27;
    localparam logic [4:0] GP   = 5'd28;
    localparam logic [4:0] SP   = 5'd29;
    localparam logic [4:0] FP   = 5'd30;
    localparam logic [4:0] RA   = 5'd31;

    // Largest value a w-bit outstanding-write counter may hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down outstanding-write counter for one register.
// Flush clears it; increment at max and decrement at zero are ignored.
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             nz
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_ok;
    logic             dec_ok;

    assign cnt  = cnt_q;
    assign full = (cnt_q == MAX);
    assign nz   = (cnt_q != '0);

    always_comb begin
        inc_ok = inc & ~full;
        dec_ok = dec & nz;
        cnt_d  = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc_ok & ~dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_ok & ~inc_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register write scoreboard.
// Define REGFILE_BYPASS_EN to forward writeback data and busy state.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_full,
    input  logic                     flush,
    output logic                     any_busy,
    output logic                     wb_err
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic [CNT_W-1:0]  cnt   [NREGS];
    logic [NREGS-1:0]  full_v;
    logic [NREGS-1:0]  nz_v;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;
    logic              wb_err_q;
    logic              wb_err_d;
    logic              wr_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok      = wr_en & ~is_zero(wr_addr);
    assign issue_full = issue_en & full_v[issue_addr];
    assign any_busy   = |nz_v;
    assign wb_err     = wb_err_q;

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign cnt[r]    = '0;
            assign full_v[r] = 1'b0;
            assign nz_v[r]   = 1'b0;
            assign inc_v[r]  = 1'b0;
            assign dec_v[r]  = 1'b0;
        end else begin : g_live
            assign inc_v[r] = issue_en & ~flush
                            & (issue_addr == ADDR_W'(r));
            assign dec_v[r] = wr_en & ~flush
                            & (wr_addr == ADDR_W'(r));
            regfile_sb_cnt #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .flush(flush),
                .inc  (inc_v[r]),
                .dec  (dec_v[r]),
                .cnt  (cnt[r]),
                .full (full_v[r]),
                .nz   (nz_v[r])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Writeback with no outstanding issue is a decode bug; keep it sticky.
    always_comb begin
        wb_err_d = wb_err_q | (wr_ok & ~flush & ~nz_v[wr_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] data;
        logic              busy;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            data = mem_q[a];
            busy = (cnt[a] != '0);
`ifdef REGFILE_BYPASS_EN
            if (rst_n && wr_ok && (wr_addr == a)) begin
                data = wr_data;
                busy = (issue_en & ~issue_full & (issue_addr == a))
                     | (cnt[a] > CNT_W'(1));
            end
`endif
            if (is_zero(a)) begin
                data = '0;
                busy = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = data;
            rd_busy[k]                  = busy;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
// Expectations adapt to the REGFILE_BYPASS_EN build option.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        issue_full;
    logic        flush;
    logic        any_busy;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_addr(issue_addr),
        .issue_full(issue_full),
        .flush     (flush),
        .any_busy  (any_busy),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(5'd0, 5'd8);
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_rd1_r8", rd_data[63:32], 32'h0);
        chk("rst_busy", {30'd0, rd_busy}, 32'h0);
        chk("rst_any_busy", {31'd0, any_busy}, 32'h0);
        chk("rst_issue_full", {31'd0, issue_full}, 32'h0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'h0);
        set_rd(5'd0, 5'd31);
        #1;
        chk("rst_rd1_r31", rd_data[63:32], 32'h0);
        chk("rst_busy_r31", {31'd0, rd_busy[1]}, 32'h0);

        set_rd(5'd8, 5'd0);
        tick(); idle(); iss(5'd8);
        tick(); idle(); wr(5'd8, 32'h3E8);
        #2;
        chk("r8_same_cyc_data", rd_data[31:0], BYP ? 32'h3E8 : 32'h0);
        chk("r8_same_cyc_busy", {31'd0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
        tick(); idle();
        #2;
        chk("r8_data", rd_data[31:0], 32'h3E8);
        chk("r8_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("r8_wb_err", {31'd0, wb_err}, 32'h0);
        wr(5'd0, 32'hFFFF_FFFF);
        tick(); idle();
        #2;
        chk("r0_zero", rd_data[63:32], 32'h0);
        chk("r0_no_wb_err", {31'd0, wb_err}, 32'h0);
        chk("r8_kept", rd_data[31:0], 32'h3E8);

        set_rd(5'd9, 5'd8);
        tick(); idle(); iss(5'd9);
        tick(); idle(); iss(5'd9);
        tick(); idle(); iss(5'd9);
        tick(); idle(); iss(5'd9);
        #2;
        chk("r9_full", {31'd0, issue_full}, 32'h1);
        chk("r9_busy3", {31'd0, rd_busy[0]}, 32'h1);
        chk("r9_any_busy", {31'd0, any_busy}, 32'h1);
        tick(); idle(); wr(5'd9, 32'h1);
        #2;
        chk("r9_full_idle", {31'd0, issue_full}, 32'h0);
        chk("r9_busy_wb1", {31'd0, rd_busy[0]}, 32'h1);
        tick(); idle(); wr(5'd9, 32'h2);
        #2;
        chk("r9_busy_wb2", {31'd0, rd_busy[0]}, 32'h1);
        tick(); idle(); wr(5'd9, 32'h3);
        #2;
        chk("r9_busy_wb3", {31'd0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
        tick(); idle();
        #2;
        chk("r9_idle_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("r9_idle_any", {31'd0, any_busy}, 32'h0);
        chk("r9_data", rd_data[31:0], 32'h3);
        chk("r9_wb_err", {31'd0, wb_err}, 32'h0);

        set_rd(5'd10, 5'd9);
        tick(); idle(); iss(5'd10);
        tick(); idle(); iss(5'd10); wr(5'd10, 32'hAA);
        #2;
        chk("r10_incdec_data", rd_data[31:0], BYP ? 32'hAA : 32'h0);
        chk("r10_incdec_busy", {31'd0, rd_busy[0]}, 32'h1);
        chk("r10_not_full", {31'd0, issue_full}, 32'h0);
        tick(); idle();
        #2;
        chk("r10_held_busy", {31'd0, rd_busy[0]}, 32'h1);
        chk("r10_data", rd_data[31:0], 32'hAA);
        wr(5'd10, 32'hBB);
        tick(); idle();
        #2;
        chk("r10_drained", {31'd0, any_busy}, 32'h0);
        chk("r10_data2", rd_data[31:0], 32'hBB);

        set_rd(5'd11, 5'd12);
        tick(); idle(); iss(5'd11);
        tick(); idle(); iss(5'd12);
        tick(); idle();
        #2;
        chk("flush_pre_busy", {30'd0, rd_busy}, 32'h3);
        flush = 1'b1;
        wr(5'd11, 32'h5);
        tick(); idle();
        #2;
        chk("flush_any", {31'd0, any_busy}, 32'h0);
        chk("flush_busy", {30'd0, rd_busy}, 32'h0);
        chk("flush_r11", rd_data[31:0], 32'h5);
        chk("flush_wb_err", {31'd0, wb_err}, 32'h0);
        wr(5'd12, 32'h7);
        tick(); idle();
        #2;
        chk("underflow_wb_err", {31'd0, wb_err}, 32'h1);
        chk("underflow_r12", rd_data[63:32], 32'h7);

        set_rd(5'd13, 5'd14);
        iss(5'd13);
        tick(); idle();
        #2;
        chk("r13_busy", {31'd0, rd_busy[0]}, 32'h1);
        rst_n = 1'b0;
        wr(5'd13, 32'h55);
        iss(5'd14);
        tick(); idle();
        rst_n = 1'b1;
        #2;
        chk("rst2_r13", rd_data[31:0], 32'h0);
        chk("rst2_busy", {30'd0, rd_busy}, 32'h0);
        chk("rst2_any", {31'd0, any_busy}, 32'h0);
        chk("rst2_wb_err", {31'd0, wb_err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
